uart_program_loader: RTL and testbench

Serial front end for the RAM programmer. It receives 8N1 UART bytes on a single pin and re-times each accepted byte into a `byte_out` / `new_byte` strobe pair sized for the programmer's 7-cycle write sequence. It drives the programmer's `programming` bus-ownership signal for the duration of a load. It counts bytes and stops after a full 16-byte RAM image.

---
 rtl/uart_program_loader_if.sv | 39 +++
 rtl/uart_program_loader.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_program_loader_if.sv
// Bus between the UART loader and its surroundings: serial input, session
// control, and the byte/strobe pair that feeds the RAM programmer.
interface uart_program_loader_if;
    logic       rx;
    logic       load_en;
    logic [7:0] byte_out;
    logic       new_byte;
    logic       programming;
    logic [4:0] byte_count;
    logic       done;
    logic       frame_err;
    logic       overrun;

    // Driver side: owns the UART line and load enable, observes the outputs.
    modport master (
        output rx,
        output load_en,
        input  byte_out,
        input  new_byte,
        input  programming,
        input  byte_count,
        input  done,
        input  frame_err,
        input  overrun
    );

    // Loader side.
    modport slave (
        input  rx,
        input  load_en,
        output byte_out,
        output new_byte,
        output programming,
        output byte_count,
        output done,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_program_loader.sv
// UART (8N1) front end for the RAM programmer. Receives bytes on rx, holds
// one in a single-entry buffer and replays each as a byte_out/new_byte pulse
// spaced for the programmer's write sequence. Stops after NUM_BYTES bytes.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned NB_HIGH      = 2,
    parameter int unsigned NB_GAP       = 10,
    parameter int unsigned NUM_BYTES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_program_loader_if.slave  bus
);

    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned EW  = $clog2(NB_GAP + 1);
    localparam int unsigned BCW = 5;

    localparam logic [CW-1:0]  HALF_BIT_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [EW-1:0]  HIGH_LAST     = EW'(NB_HIGH - 1);
    localparam logic [EW-1:0]  GAP_LAST      = EW'(NB_GAP - NB_HIGH - 1);
    localparam logic [BCW-1:0] IMAGE_BYTES   = BCW'(NUM_BYTES);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        E_IDLE,
        E_HIGH,
        E_GAP
    } em_state_e;

    // ------------------------------------------------------------------
    // rx synchronizer
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    // Two-flop synchronizer, preset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rtim_q, rtim_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_valid_c;
    logic          rx_ferr_c;

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= R_IDLE;
            rtim_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rtim_q     <= rtim_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Receiver next state: mid-bit sampling, start glitch rejection, stop check.
    always_comb begin
        rx_state_d = rx_state_q;
        rtim_d     = rtim_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_valid_c = 1'b0;
        rx_ferr_c  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (!rxs_q) begin
                    rx_state_d = R_START;
                    rtim_d     = '0;
                end
            end
            R_START: begin
                if (rtim_q == HALF_BIT_LAST) begin
                    rtim_d = '0;
                    if (rxs_q) begin
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_state_d = R_DATA;
                        bit_idx_d  = '0;
                    end
                end else begin
                    rtim_d = rtim_q + CW'(1);
                end
            end
            R_DATA: begin
                if (rtim_q == FULL_BIT_LAST) begin
                    rtim_d  = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    rtim_d = rtim_q + CW'(1);
                end
            end
            R_STOP: begin
                if (rtim_q == FULL_BIT_LAST) begin
                    rtim_d     = '0;
                    rx_state_d = R_IDLE;
                    if (rxs_q) begin
                        rx_valid_c = 1'b1;
                    end else begin
                        rx_ferr_c = 1'b1;
                    end
                end else begin
                    rtim_d = rtim_q + CW'(1);
                end
            end
            default: begin
                rx_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding buffer, session control and strobe emitter
    // ------------------------------------------------------------------
    em_state_e      em_state_q, em_state_d;
    logic [EW-1:0]  etim_q, etim_d;
    logic [7:0]     buf_q, buf_d;
    logic           buf_full_q, buf_full_d;
    logic [7:0]     byte_out_q, byte_out_d;
    logic           new_byte_q, new_byte_d;
    logic           prog_q, prog_d;
    logic [BCW-1:0] count_q, count_d;
    logic           done_q, done_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           take_c;
    logic           accept_c;

    // Emitter and session state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            em_state_q <= E_IDLE;
            etim_q     <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            byte_out_q <= '0;
            new_byte_q <= 1'b0;
            prog_q     <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            em_state_q <= em_state_d;
            etim_q     <= etim_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            byte_out_q <= byte_out_d;
            new_byte_q <= new_byte_d;
            prog_q     <= prog_d;
            count_q    <= count_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Buffer accept, pulse sequencing and session start/end; abort has final say.
    always_comb begin
        em_state_d = em_state_q;
        etim_d     = etim_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        byte_out_d = byte_out_q;
        new_byte_d = new_byte_q;
        prog_d     = prog_q;
        count_d    = count_q;
        done_d     = done_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;

        // A take frees the buffer on the same edge, so a byte landing then is kept.
        take_c   = (em_state_q == E_IDLE) && buf_full_q && prog_q && (count_q < IMAGE_BYTES);
        accept_c = rx_valid_c && prog_q && (!buf_full_q || take_c);

        if (rx_ferr_c) begin
            ferr_d = 1'b1;
        end
        if (rx_valid_c && prog_q && buf_full_q && !take_c) begin
            ovr_d = 1'b1;
        end

        if (take_c) begin
            buf_full_d = 1'b0;
        end
        if (accept_c) begin
            buf_d      = shift_q;
            buf_full_d = 1'b1;
        end

        case (em_state_q)
            E_IDLE: begin
                if (take_c) begin
                    byte_out_d = buf_q;
                    new_byte_d = 1'b1;
                    count_d    = count_q + BCW'(1);
                    etim_d     = '0;
                    em_state_d = E_HIGH;
                end
            end
            E_HIGH: begin
                if (etim_q == HIGH_LAST) begin
                    new_byte_d = 1'b0;
                    etim_d     = '0;
                    em_state_d = E_GAP;
                end else begin
                    etim_d = etim_q + EW'(1);
                end
            end
            E_GAP: begin
                if (etim_q == GAP_LAST) begin
                    etim_d     = '0;
                    em_state_d = E_IDLE;
                    if (count_q == IMAGE_BYTES) begin
                        done_d = 1'b1;
                        prog_d = 1'b0;
                    end
                end else begin
                    etim_d = etim_q + EW'(1);
                end
            end
            default: begin
                em_state_d = E_IDLE;
                new_byte_d = 1'b0;
            end
        endcase

        if (bus.load_en && !prog_q && !done_q) begin
            prog_d = 1'b1;
        end

        if (!bus.load_en) begin
            prog_d     = 1'b0;
            done_d     = 1'b0;
            count_d    = '0;
            buf_full_d = 1'b0;
            em_state_d = E_IDLE;
            etim_d     = '0;
            new_byte_d = 1'b0;
        end
    end

    assign bus.byte_out    = byte_out_q;
    assign bus.new_byte    = new_byte_q;
    assign bus.programming = prog_q;
    assign bus.byte_count  = count_q;
    assign bus.done        = done_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: UART bytes in, pulses observed by a
// monitor and matched against a scoreboard of expected bytes.
module tb_uart_program_loader;

    localparam int CLKS      = 16;
    localparam int NB_HIGH   = 2;
    localparam int NB_GAP    = 10;
    localparam int NUM_BYTES = 16;
    // Start-bit drive to first new_byte high: sync(2) + idle detect(1) +
    // half bit + 9 full bits to the stop sample + 1 to the strobe.
    localparam int LAT       = 4 + CLKS / 2 + 9 * CLKS;

    typedef struct {
        logic [7:0] data;
        int         rise_cyc;
        int         width;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    pulse_t     obs_q[$];
    int         obs_rd    = 0;
    int         prev_rise = 0;
    bit         have_prev = 1'b0;

    logic       prev_nb   = 1'b0;
    logic [7:0] cur_data  = '0;
    int         cur_rise  = 0;
    int         hi_len    = 0;
    int         last_rise = 0;

    uart_program_loader_if bus_if ();

    uart_program_loader #(
        .CLKS_PER_BIT (CLKS),
        .NB_HIGH      (NB_HIGH),
        .NB_GAP       (NB_GAP),
        .NUM_BYTES    (NUM_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every new_byte pulse (data, rise cycle, width).
    always @(negedge clk) begin
        if (bus_if.new_byte === 1'b1 && !prev_nb) begin
            cur_data  = bus_if.byte_out;
            cur_rise  = cyc;
            last_rise = cyc;
            hi_len    = 1;
        end else if (bus_if.new_byte === 1'b1) begin
            hi_len = hi_len + 1;
        end else if (prev_nb) begin
            obs_q.push_back('{cur_data, cur_rise, hi_len});
        end
        prev_nb = (bus_if.new_byte === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame; t0 is the cycle the start bit was driven.
    task automatic send_byte(input logic [7:0] d, input logic stop_ok, input bit expect_pulse,
                             output int t0);
        if (expect_pulse) exp_q.push_back(d);
        @(posedge clk); #1;
        bus_if.rx = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CLKS) @(posedge clk);
            #1 bus_if.rx = d[i];
        end
        repeat (CLKS) @(posedge clk);
        #1 bus_if.rx = stop_ok;
        repeat (CLKS) @(posedge clk);
        #1 bus_if.rx = 1'b1;
    endtask

    // Match observed pulses against the expected-byte queue.
    task automatic drain(input int exp_width);
        pulse_t     o;
        logic [7:0] e;
        check("pulse_count", 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            o = obs_q[obs_rd];
            obs_rd++;
            e = exp_q.pop_front();
            check("byte_out", 32'(o.data), 32'(e));
            check("pulse_width", 32'(o.width), 32'(exp_width));
            if (have_prev) check("rise_spacing", 32'(o.rise_cyc - prev_rise >= NB_GAP), 32'd1);
            prev_rise = o.rise_cyc;
            have_prev = 1'b1;
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        bus_if.rx      = 1'b1;
        bus_if.load_en = 1'b0;

        // 1. Idle after reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cycles(200);
        check("rst_byte_out", 32'(bus_if.byte_out), 32'd0);
        check("rst_new_byte", 32'(bus_if.new_byte), 32'd0);
        check("rst_programming", 32'(bus_if.programming), 32'd0);
        check("rst_byte_count", 32'(bus_if.byte_count), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
        check("rst_overrun", 32'(bus_if.overrun), 32'd0);
        drain(NB_HIGH);

        // 2. Single byte
        bus_if.load_en = 1'b1;
        cycles(1);
        check("programming_rise", 32'(bus_if.programming), 32'd1);
        send_byte(8'hA5, 1'b1, 1'b1, t0);
        check("rx_to_pulse_latency", 32'(last_rise - t0), 32'(LAT));
        check("single_byte_out", 32'(bus_if.byte_out), 32'hA5);
        check("single_count", 32'(bus_if.byte_count), 32'd1);
        drain(NB_HIGH);

        // 3. Full image, then an extra byte that must not be emitted
        bus_if.load_en = 1'b0;
        cycles(2);
        check("restart_count", 32'(bus_if.byte_count), 32'd0);
        bus_if.load_en = 1'b1;
        cycles(2);
        for (int i = 0; i < NUM_BYTES; i++) send_byte(8'(i), 1'b1, 1'b1, t0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cyc == last_rise + NB_GAP - 1) check("done_early", 32'(bus_if.done), 32'd0);
            if (cyc == last_rise + NB_GAP) break;
        end
        check("done_wait", 32'(cyc - last_rise), 32'(NB_GAP));
        check("image_done", 32'(bus_if.done), 32'd1);
        check("image_programming", 32'(bus_if.programming), 32'd0);
        check("image_count", 32'(bus_if.byte_count), 32'(NUM_BYTES));
        drain(NB_HIGH);
        send_byte(8'hFF, 1'b1, 1'b0, t0);
        cycles(20);
        check("post_done_count", 32'(bus_if.byte_count), 32'(NUM_BYTES));
        check("post_done_done", 32'(bus_if.done), 32'd1);
        drain(NB_HIGH);
        bus_if.load_en = 1'b0;
        cycles(1);
        check("drop_done", 32'(bus_if.done), 32'd0);
        check("drop_count", 32'(bus_if.byte_count), 32'd0);

        // 5. Start-bit glitch
        bus_if.load_en = 1'b1;
        cycles(2);
        bus_if.rx = 1'b0;
        cycles(3);
        bus_if.rx = 1'b1;
        cycles(200);
        check("glitch_frame_err", 32'(bus_if.frame_err), 32'd0);
        check("glitch_count", 32'(bus_if.byte_count), 32'd0);
        drain(NB_HIGH);

        // 4. Framing error, then a good copy of the same byte
        send_byte(8'h3C, 1'b0, 1'b0, t0);
        cycles(2 * CLKS);
        check("ferr_set", 32'(bus_if.frame_err), 32'd1);
        check("ferr_count", 32'(bus_if.byte_count), 32'd0);
        drain(NB_HIGH);
        send_byte(8'h3C, 1'b1, 1'b1, t0);
        check("ferr_good_count", 32'(bus_if.byte_count), 32'd1);
        check("ferr_good_byte", 32'(bus_if.byte_out), 32'h3C);
        drain(NB_HIGH);

        // 6. Abort in the middle of a pulse
        bus_if.load_en = 1'b0;
        cycles(2);
        bus_if.load_en = 1'b1;
        cycles(2);
        for (int i = 0; i < 5; i++) send_byte(8'h51 + 8'(i), 1'b1, 1'b1, t0);
        check("five_count", 32'(bus_if.byte_count), 32'd5);
        drain(NB_HIGH);
        fork
            send_byte(8'h66, 1'b1, 1'b1, t0);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (bus_if.new_byte === 1'b1) break;
                end
                check("abort_pulse_seen", 32'(bus_if.new_byte), 32'd1);
                check("abort_pre_count", 32'(bus_if.byte_count), 32'd6);
                bus_if.load_en = 1'b0;
                @(negedge clk);
                check("abort_new_byte", 32'(bus_if.new_byte), 32'd0);
                check("abort_programming", 32'(bus_if.programming), 32'd0);
                check("abort_count", 32'(bus_if.byte_count), 32'd0);
            end
        join
        cycles(4);
        drain(1);
        bus_if.load_en = 1'b1;
        cycles(2);
        send_byte(8'h11, 1'b1, 1'b1, t0);
        check("reload_count", 32'(bus_if.byte_count), 32'd1);
        check("reload_byte", 32'(bus_if.byte_out), 32'h11);
        drain(NB_HIGH);
        check("final_overrun", 32'(bus_if.overrun), 32'd0);
        check("final_frame_err", 32'(bus_if.frame_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
